// File: rtl/potato1_datapath_if.sv
// Byte output/input handshake bundle between the Potato-1 datapath and its IO peer.
// master = datapath side, slave = external producer/consumer side.
interface potato1_datapath_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output out_data, out_valid, in_ready,
        input  out_ready, in_data, in_valid
    );

    modport slave (
        input  out_data, out_valid, in_ready,
        output out_ready, in_data, in_valid
    );
endinterface

// File: rtl/potato1_datapath.sv
// Potato-1 execution/memory datapath: program counter, byte tape with data pointer, byte IO handshake.
// Optional POTATO1_DP_TAPE_SATURATE_EN: pointer saturates at tape bounds and raises sticky ptr_fault.
module potato1_datapath #(
    parameter int PC_W  = 8,
    parameter int PTR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc,
    input  logic [5:0]        command,
    output logic [3:0]        instruction,
    output logic              zeroflag,
    output logic              iowait,
    output logic [PC_W-1:0]   prog_addr,
    input  logic [3:0]        prog_data,
    potato1_datapath_if.master io
`ifdef POTATO1_DP_TAPE_SATURATE_EN
    ,
    output logic              ptr_fault
`endif
);

    localparam int DEPTH = 2 ** PTR_W;
    localparam logic [PC_W-1:0]  PC_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OUT_WAIT = 2'd1,
        IN_WAIT  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [PC_W-1:0]   pc_q, pc_next;
    logic [PTR_W-1:0]  ptr, ptr_next;
    logic [7:0]        tape [DEPTH];
    logic [7:0]        cell_cur, cell_next;
    logic [7:0]        out_data_q;
    logic              out_valid_q, in_ready_q;
    logic              issue_out, issue_in, out_done, in_done, core_op;
`ifdef POTATO1_DP_TAPE_SATURATE_EN
    logic              bound_hit;
    logic              fault_q;
`endif

    assign cell_cur     = tape[ptr];
    assign instruction  = prog_data;
    assign prog_addr    = pc_q;
    assign zeroflag     = (cell_cur == 8'h00);
    assign iowait       = (state != IDLE);
    assign io.out_data  = out_data_q;
    assign io.out_valid = out_valid_q;
    assign io.in_ready  = in_ready_q;
`ifdef POTATO1_DP_TAPE_SATURATE_EN
    assign ptr_fault    = fault_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Output handshake takes priority over input when both IO bits are set.
    always_comb begin
        state_next = state;
        issue_out  = 1'b0;
        issue_in   = 1'b0;
        out_done   = 1'b0;
        in_done    = 1'b0;
        core_op    = 1'b0;
        case (state)
            IDLE: begin
                if (command[4]) begin
                    issue_out  = 1'b1;
                    state_next = OUT_WAIT;
                end else if (command[5]) begin
                    issue_in   = 1'b1;
                    state_next = IN_WAIT;
                end else begin
                    core_op    = 1'b1;
                end
            end
            OUT_WAIT: begin
                if (out_valid_q && io.out_ready) begin
                    out_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            IN_WAIT: begin
                if (in_ready_q && io.in_valid) begin
                    in_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pc_next = pc_q;
        case (pc)
            2'b01:   pc_next = pc_q + PC_ONE;
            2'b10:   pc_next = pc_q - PC_ONE;
            default: pc_next = pc_q;
        endcase
    end

    always_comb begin
        cell_next = cell_cur;
        case (command[1:0])
            2'b01:   cell_next = cell_cur + 8'd1;
            2'b10:   cell_next = cell_cur - 8'd1;
            default: cell_next = cell_cur;
        endcase
    end

    always_comb begin
        ptr_next = ptr;
`ifdef POTATO1_DP_TAPE_SATURATE_EN
        bound_hit = 1'b0;
        case (command[3:2])
            2'b01: begin
                if (ptr == {PTR_W{1'b1}}) bound_hit = 1'b1;
                else                      ptr_next  = ptr + PTR_ONE;
            end
            2'b10: begin
                if (ptr == {PTR_W{1'b0}}) bound_hit = 1'b1;
                else                      ptr_next  = ptr - PTR_ONE;
            end
            default: ptr_next = ptr;
        endcase
`else
        case (command[3:2])
            2'b01:   ptr_next = ptr + PTR_ONE;
            2'b10:   ptr_next = ptr - PTR_ONE;
            default: ptr_next = ptr;
        endcase
`endif
    end

    // Cell op uses the pre-update ptr, so tape write and ptr move share one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= '0;
            ptr         <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tape[i] <= 8'h00;
`ifdef POTATO1_DP_TAPE_SATURATE_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            if (state == IDLE) pc_q <= pc_next;
            if (core_op) begin
                tape[ptr] <= cell_next;
                ptr       <= ptr_next;
            end
            if (in_done) tape[ptr] <= io.in_data;
            if (issue_out) begin
                out_data_q  <= cell_cur;
                out_valid_q <= 1'b1;
            end
            if (out_done) out_valid_q <= 1'b0;
            if (issue_in) in_ready_q <= 1'b1;
            if (in_done)  in_ready_q <= 1'b0;
`ifdef POTATO1_DP_TAPE_SATURATE_EN
            if (core_op && bound_hit) fault_q <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_potato1_datapath.sv
// Self-checking bench for potato1_datapath: vector table, hand-written IO/bound sequences,
// and randomized traffic against an arithmetic reference model.
module tb_potato1_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pc;
    logic [5:0] command;
    logic [3:0] instruction;
    logic       zeroflag;
    logic       iowait;
    logic [7:0] prog_addr;
    logic [3:0] prog_data;
`ifdef POTATO1_DP_TAPE_SATURATE_EN
    logic       ptr_fault;
`endif

    potato1_datapath_if bus ();

    potato1_datapath #(.PC_W(8), .PTR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .command     (command),
        .instruction (instruction),
        .zeroflag    (zeroflag),
        .iowait      (iowait),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .io          (bus.master)
`ifdef POTATO1_DP_TAPE_SATURATE_EN
        ,
        .ptr_fault   (ptr_fault)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: tape as integer array, pending IO as two flags.
    int       m_pc, m_ptr, m_out_data;
    int       m_tape [16];
    bit       m_out_v, m_in_r, m_fault;

    task automatic model_reset();
        m_pc = 0; m_ptr = 0; m_out_data = 0;
        m_out_v = 0; m_in_r = 0; m_fault = 0;
        for (int i = 0; i < 16; i++) m_tape[i] = 0;
    endtask

    task automatic model_edge();
        int d, np;
        if (!m_out_v && !m_in_r) begin
            if (pc == 2'b01) m_pc = (m_pc + 1) % 256;
            else if (pc == 2'b10) m_pc = (m_pc + 255) % 256;
            if (command[4]) begin
                m_out_data = m_tape[m_ptr];
                m_out_v = 1;
            end else if (command[5]) begin
                m_in_r = 1;
            end else begin
                d = int'(command[0]) - int'(command[1]);
                m_tape[m_ptr] = (m_tape[m_ptr] + d + 256) % 256;
                np = m_ptr + int'(command[2]) - int'(command[3]);
`ifdef POTATO1_DP_TAPE_SATURATE_EN
                if (np < 0 || np > 15) m_fault = 1;
                else m_ptr = np;
`else
                m_ptr = (np + 16) % 16;
`endif
            end
        end else if (m_out_v) begin
            if (bus.out_ready) m_out_v = 0;
        end else begin
            if (bus.in_valid) begin
                m_tape[m_ptr] = int'(bus.in_data);
                m_in_r = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        model_edge();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_model(input string tag);
        check({tag, ".prog_addr"}, int'(prog_addr), m_pc);
        check({tag, ".zeroflag"}, int'(zeroflag), int'(m_tape[m_ptr] == 0));
        check({tag, ".iowait"}, int'(iowait), int'(m_out_v | m_in_r));
        check({tag, ".out_valid"}, int'(bus.out_valid), int'(m_out_v));
        check({tag, ".in_ready"}, int'(bus.in_ready), int'(m_in_r));
        check({tag, ".out_data"}, int'(bus.out_data), m_out_data);
`ifdef POTATO1_DP_TAPE_SATURATE_EN
        check({tag, ".ptr_fault"}, int'(ptr_fault), int'(m_fault));
`endif
    endtask

    typedef struct {
        logic [1:0] pc;
        logic [5:0] cmd;
        logic [3:0] pdata;
        int         exp_addr;
        int         exp_zf;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{2'b01, 6'b000001, 4'h3, 1,    0};
        vecs[1]  = '{2'b01, 6'b000001, 4'h7, 2,    0};
        vecs[2]  = '{2'b00, 6'b000001, 4'hA, 2,    0};
        vecs[3]  = '{2'b11, 6'b000010, 4'h0, 2,    0};
        vecs[4]  = '{2'b00, 6'b000011, 4'hF, 2,    0};
        vecs[5]  = '{2'b10, 6'b000010, 4'h5, 1,    0};
        vecs[6]  = '{2'b10, 6'b000010, 4'h1, 0,    1};
        vecs[7]  = '{2'b10, 6'b000010, 4'hC, 255,  0};
        vecs[8]  = '{2'b01, 6'b000100, 4'h2, 0,    1};
        vecs[9]  = '{2'b00, 6'b000101, 4'h9, 0,    1};
        vecs[10] = '{2'b00, 6'b001000, 4'h4, 0,    0};
        vecs[11] = '{2'b00, 6'b001100, 4'h8, 0,    0};
        vecs[12] = '{2'b00, 6'b001010, 4'hB, 0,    0};
        vecs[13] = '{2'b00, 6'b000001, 4'hE, 0,    1};

        rst = 1'b1; pc = 2'b00; command = 6'd0; prog_data = 4'h0;
        bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;

        do_reset();
        check("rst.prog_addr", int'(prog_addr), 0);
        check("rst.zeroflag", int'(zeroflag), 1);
        check("rst.iowait", int'(iowait), 0);
        check("rst.out_valid", int'(bus.out_valid), 0);
        check("rst.in_ready", int'(bus.in_ready), 0);
        check("rst.out_data", int'(bus.out_data), 0);

        // Vector table: cell/ptr/pc arithmetic in IDLE.
        for (int i = 0; i < 14; i++) begin
            pc = vecs[i].pc; command = vecs[i].cmd; prog_data = vecs[i].pdata;
            tick();
            check($sformatf("vec%0d.prog_addr", i), int'(prog_addr), vecs[i].exp_addr);
            check($sformatf("vec%0d.zeroflag", i), int'(zeroflag), vecs[i].exp_zf);
            check($sformatf("vec%0d.instruction", i), int'(instruction), int'(vecs[i].pdata));
            check($sformatf("vec%0d.iowait", i), int'(iowait), 0);
        end

        // Output handshake with a stalled consumer.
        do_reset();
        pc = 2'b00; command = 6'b000001;
        for (int i = 0; i < 65; i++) tick();
        pc = 2'b01; command = 6'b010000; bus.out_ready = 1'b0;
        tick();
        check("out.issue.iowait", int'(iowait), 1);
        check("out.issue.out_valid", int'(bus.out_valid), 1);
        check("out.issue.out_data", int'(bus.out_data), 8'h41);
        check("out.issue.prog_addr", int'(prog_addr), 1);
        for (int i = 0; i < 3; i++) begin
            command = 6'($urandom_range(1, 63)); pc = 2'b01;
            tick();
            check("out.stall.out_valid", int'(bus.out_valid), 1);
            check("out.stall.out_data", int'(bus.out_data), 8'h41);
            check("out.stall.prog_addr", int'(prog_addr), 1);
        end
        command = 6'b000001; bus.out_ready = 1'b1;
        tick();
        check("out.done.out_valid", int'(bus.out_valid), 0);
        check("out.done.iowait", int'(iowait), 0);
        check("out.done.prog_addr", int'(prog_addr), 1);
        check("out.done.zeroflag", int'(zeroflag), 0);
        check("out.done.model", int'(bus.out_data), m_out_data);
        bus.out_ready = 1'b0;

        // Input handshake loading zero into a nonzero cell.
        pc = 2'b00; command = 6'b100000;
        tick();
        check("in.issue.in_ready", int'(bus.in_ready), 1);
        check("in.issue.iowait", int'(iowait), 1);
        command = 6'd0;
        tick();
        tick();
        check("in.stall.iowait", int'(iowait), 1);
        check("in.stall.zeroflag", int'(zeroflag), 0);
        bus.in_valid = 1'b1; bus.in_data = 8'h00;
        tick();
        check("in.done.zeroflag", int'(zeroflag), 1);
        check("in.done.iowait", int'(iowait), 0);
        check("in.done.in_ready", int'(bus.in_ready), 0);
        bus.in_valid = 1'b0;

        // Pointer upper bound.
        do_reset();
        command = 6'b000100;
        for (int i = 0; i < 15; i++) tick();
        command = 6'b000001;
        tick();
        check("bound.cell15.zeroflag", int'(zeroflag), 0);
        command = 6'b000100;
        tick();
`ifdef POTATO1_DP_TAPE_SATURATE_EN
        check("bound.sat.zeroflag", int'(zeroflag), 0);
        check("bound.sat.ptr_fault", int'(ptr_fault), 1);
        command = 6'b000000;
        tick();
        check("bound.sticky.ptr_fault", int'(ptr_fault), 1);
        do_reset();
        check("bound.rst.ptr_fault", int'(ptr_fault), 0);
`else
        check("bound.wrap.zeroflag", int'(zeroflag), 1);
        command = 6'b001000;
        tick();
        check("bound.wrapback.zeroflag", int'(zeroflag), 0);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0)      command = 6'b010000 | 6'($urandom_range(0, 47));
            else if (r == 1) command = 6'b100000 | 6'($urandom_range(0, 15));
            else             command = 6'($urandom_range(0, 15));
            pc = 2'($urandom_range(0, 3));
            prog_data = 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 2) == 0);
            bus.in_valid  = ($urandom_range(0, 2) == 0);
            bus.in_data   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            tick();
            check_model("rand");
            check("rand.instruction", int'(instruction), int'(prog_data));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
